// File: rtl/imm_enc_pkg.sv
// Shared definitions for the immediate materializer.
// Contents:
//   - RV64I opcode and funct3 constants used by the emitted sequences
//   - state_t     : controller state (IDLE / EMIT)
//   - seq_len_t   : sequence class chosen on accept (S12 / S32 / GEN)
//   - inst_fmt_t  : instruction field layout selected in inst_pack
//   - seq_words() : number of words emitted for a sequence class
package imm_enc_pkg;

    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_IMM32 = 7'h1B;

    localparam logic [2:0] F3_ADDI  = 3'b000;
    localparam logic [2:0] F3_SLLI  = 3'b001;
    localparam logic [2:0] F3_ORI   = 3'b110;
    localparam logic [2:0] F3_ADDIW = 3'b000;

    typedef enum logic {IDLE, EMIT} state_t;

    typedef enum logic [1:0] {S12, S32, GEN} seq_len_t;

    typedef enum logic [1:0] {FMT_I, FMT_U, FMT_SH} inst_fmt_t;

    function automatic logic [3:0] seq_words(input seq_len_t len);
        case (len)
            S12:     return 4'd1;
            S32:     return 4'd2;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/imm_materializer_if.sv
// Request / instruction-stream bundle for imm_materializer.
// Signals:
//   req_valid/req_ready   request handshake (front end -> materializer)
//   req_value, req_rd     constant to load and destination register
//   inst_valid/inst_ready instruction handshake (materializer -> issue path)
//   inst, inst_last       encoded word and end-of-sequence marker
// Modports: master = front end / consumer side, slave = materializer.
interface imm_materializer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int INST_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [DATA_WIDTH-1:0] req_value;
    logic [4:0]            req_rd;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [INST_WIDTH-1:0] inst;
    logic                  inst_last;

    modport master (
        output req_valid, req_value, req_rd, inst_ready,
        input  req_ready, inst_valid, inst, inst_last
    );

    modport slave (
        input  req_valid, req_value, req_rd, inst_ready,
        output req_ready, inst_valid, inst, inst_last
    );
endinterface

// File: rtl/imm_materializer_inst_pack.sv
// inst_pack: combinational RV32/RV64 instruction word packer.
// Ports:
//   i_fmt     field layout (I-type, U-type, shift-immediate)
//   i_opcode  7-bit opcode
//   i_funct3  funct3 field (ignored for U-type)
//   i_rd      destination register
//   i_rs1     source register (ignored for U-type)
//   i_imm12   I-type immediate
//   i_imm20   U-type immediate (upper 20 bits)
//   i_shamt   6-bit shift amount; imm[11:6] forced to zero
//   o_inst    packed 32-bit instruction
module inst_pack
    import imm_enc_pkg::*;
(
    input  inst_fmt_t   i_fmt,
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [11:0] i_imm12,
    input  logic [19:0] i_imm20,
    input  logic [5:0]  i_shamt,
    output logic [31:0] o_inst
);
    always_comb begin
        o_inst = {i_imm12, i_rs1, i_funct3, i_rd, i_opcode};
        case (i_fmt)
            FMT_U:   o_inst = {i_imm20, i_rd, i_opcode};
            FMT_SH:  o_inst = {6'b000000, i_shamt, i_rs1, i_funct3, i_rd, i_opcode};
            default: ;
        endcase
    end
endmodule

// File: rtl/imm_materializer.sv
// imm_materializer: expands a 64-bit constant into the RV64I sequence that
// loads it into rd (1 word ADDI, 2 words LUI/ADDIW, or 8 words
// LUI/ADDIW followed by three SLLI/ORI pairs).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; abandons any sequence in flight
//   bus    imm_materializer_if.slave: request in, registered instruction out
module imm_materializer
    import imm_enc_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int INST_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    imm_materializer_if.slave bus
);
    state_t                r_state, w_state_next;
    seq_len_t              r_len, w_len_next;
    logic [2:0]            r_step, w_step_next;
    logic [4:0]            r_rd, w_rd_next;
    logic [DATA_WIDTH-1:0] r_value, w_value_next;
    logic [INST_WIDTH-1:0] r_inst, w_inst_next;
    logic                  r_valid, w_valid_next;
    logic                  r_last, w_last_next;

    // Classification of the incoming constant: how many top bits are pure sign copies.
    seq_len_t w_req_class;
    always_comb begin
        if (&bus.req_value[63:11] || ~|bus.req_value[63:11])
            w_req_class = S12;
        else if (&bus.req_value[63:31] || ~|bus.req_value[63:31])
            w_req_class = S32;
        else
            w_req_class = GEN;
    end

    // Word generator source: in IDLE it encodes word 0 straight from the request so
    // the first word is registered on the accept edge; in EMIT it encodes the next step.
    logic [63:0] w_src_value;
    logic [4:0]  w_src_rd;
    seq_len_t    w_src_len;
    logic [2:0]  w_src_step;
    always_comb begin
        if (r_state == IDLE) begin
            w_src_value = bus.req_value;
            w_src_rd    = bus.req_rd;
            w_src_len   = w_req_class;
            w_src_step  = 3'd0;
        end else begin
            w_src_value = r_value;
            w_src_rd    = r_rd;
            w_src_len   = r_len;
            w_src_step  = r_step + 3'd1;
        end
    end

    // The LUI/ADDIW pair loads a 32-bit value X: the upper 32 bits of V for GEN, the low 32 otherwise.
    logic [31:0] w_hi_src;
    logic [19:0] w_hi;
    logic [11:0] w_lo;
    assign w_hi_src = (w_src_len == GEN) ? w_src_value[63:32] : w_src_value[31:0];
    // ADDIW sign-extends LO, so HI is rounded up whenever LO bit 11 is set.
    assign w_hi     = w_hi_src[31:12] + {19'd0, w_hi_src[11]};
    assign w_lo     = w_hi_src[11:0];

    inst_fmt_t   w_fmt;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [11:0] w_imm12;
    logic [5:0]  w_shamt;
    always_comb begin
        w_fmt    = FMT_I;
        w_opcode = OP_IMM;
        w_funct3 = F3_ADDI;
        w_rs1    = w_src_rd;
        w_imm12  = 12'd0;
        w_shamt  = 6'd0;
        if (w_src_len == S12) begin
            w_rs1   = 5'd0;
            w_imm12 = w_src_value[11:0];
        end else begin
            case (w_src_step)
                3'd0: begin w_fmt = FMT_U; w_opcode = OP_LUI; end
                3'd1: begin w_opcode = OP_IMM32; w_funct3 = F3_ADDIW; w_imm12 = w_lo; end
                3'd2: begin w_fmt = FMT_SH; w_funct3 = F3_SLLI; w_shamt = 6'd11; end
                3'd3: begin w_funct3 = F3_ORI; w_imm12 = {1'b0, w_src_value[31:21]}; end
                3'd4: begin w_fmt = FMT_SH; w_funct3 = F3_SLLI; w_shamt = 6'd11; end
                3'd5: begin w_funct3 = F3_ORI; w_imm12 = {1'b0, w_src_value[20:10]}; end
                3'd6: begin w_fmt = FMT_SH; w_funct3 = F3_SLLI; w_shamt = 6'd10; end
                default: begin w_funct3 = F3_ORI; w_imm12 = {2'b00, w_src_value[9:0]}; end
            endcase
        end
    end

    logic [INST_WIDTH-1:0] w_word;
    logic                  w_word_last;

    inst_pack u_inst_pack (
        .i_fmt    (w_fmt),
        .i_opcode (w_opcode),
        .i_funct3 (w_funct3),
        .i_rd     (w_src_rd),
        .i_rs1    (w_rs1),
        .i_imm12  (w_imm12),
        .i_imm20  (w_hi),
        .i_shamt  (w_shamt),
        .o_inst   (w_word)
    );

    assign w_word_last = ({1'b0, w_src_step} == (seq_words(w_src_len) - 4'd1));

    always_comb begin
        w_state_next = r_state;
        w_len_next   = r_len;
        w_step_next  = r_step;
        w_rd_next    = r_rd;
        w_value_next = r_value;
        w_inst_next  = r_inst;
        w_valid_next = r_valid;
        w_last_next  = r_last;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_state_next = EMIT;
                    w_len_next   = w_req_class;
                    w_step_next  = 3'd0;
                    w_rd_next    = bus.req_rd;
                    w_value_next = bus.req_value;
                    w_inst_next  = w_word;
                    w_last_next  = w_word_last;
                    w_valid_next = 1'b1;
                end
            end
            EMIT: begin
                // inst_valid is always high in EMIT, so inst_ready alone marks a transfer.
                if (bus.inst_ready) begin
                    if (r_last) begin
                        w_state_next = IDLE;
                        w_valid_next = 1'b0;
                        w_inst_next  = '0;
                        w_last_next  = 1'b0;
                    end else begin
                        w_step_next  = r_step + 3'd1;
                        w_inst_next  = w_word;
                        w_last_next  = w_word_last;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_len   <= S12;
            r_step  <= 3'd0;
            r_rd    <= 5'd0;
            r_value <= '0;
            r_inst  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_len   <= w_len_next;
            r_step  <= w_step_next;
            r_rd    <= w_rd_next;
            r_value <= w_value_next;
            r_inst  <= w_inst_next;
            r_valid <= w_valid_next;
            r_last  <= w_last_next;
        end
    end

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.inst_valid = r_valid;
    assign bus.inst       = r_inst;
    assign bus.inst_last  = r_last;
endmodule
